calc_port_initiator: RTL and testbench

- Synthesizable request initiator for one calc1 request/response port. It drives reqN_cmd_in/reqN_data_in and collects out_respN/out_dataN.
- Takes one transaction (command plus two operands) from a host valid/ready interface and serialises it onto the calc1 request bus.
- Waits for the response and returns result, response code and measured latency to the host.
- Four instances, one per port, replace behavioural bench drivers and are reused in FPGA bring-up.

---
 rtl/calc_port_initiator.sv | 166 ++++++++++++++++
 tb/tb_calc_port_initiator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_port_initiator.sv
// Host-side initiator for one calc1 request/response port: serialises a command
// plus two operands onto the request bus and returns the response to the host.
module calc_port_initiator #(
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 4,
  parameter int RESP_W  = 2,
  parameter int TIMEOUT = 64,
  parameter int LAT_W   = 8
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_op,
  input  logic [DATA_W-1:0] cmd_data1,
  input  logic [DATA_W-1:0] cmd_data2,
  output logic [CMD_W-1:0]  req_cmd_out,
  output logic [DATA_W-1:0] req_data_out,
  input  logic [RESP_W-1:0] out_resp_in,
  input  logic [DATA_W-1:0] out_data_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RESP_W-1:0] res_resp,
  output logic [DATA_W-1:0] res_data,
  output logic              res_timeout,
  output logic [LAT_W-1:0]  res_latency,
  output logic              busy,
  output logic              err_unexpected
);

  localparam logic [DATA_W-1:0] DATA_ZERO   = {DATA_W{1'b0}};
  localparam logic [CMD_W-1:0]  CMD_ZERO    = {CMD_W{1'b0}};
  localparam logic [RESP_W-1:0] RESP_ZERO   = {RESP_W{1'b0}};
  localparam logic [LAT_W-1:0]  LAT_ZERO    = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0]  LAT_ONE     = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0]  LAT_MAX     = {LAT_W{1'b1}};
  localparam logic [LAT_W-1:0]  LAT_TIMEOUT = LAT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND_OP1  = 3'd1,
    S_SEND_OP2  = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  op2_q;
  logic [LAT_W-1:0]   lat_q;
  logic [LAT_W-1:0]   lat_d;
  logic [CMD_W-1:0]   req_cmd_q;
  logic [DATA_W-1:0]  req_data_q;
  logic               res_valid_q;
  logic [RESP_W-1:0]  res_resp_q;
  logic [DATA_W-1:0]  res_data_q;
  logic               res_timeout_q;
  logic [LAT_W-1:0]   res_latency_q;
  logic               err_q;
  logic               resp_seen_s;

  // Saturating latency increment; the counter must never wrap back to zero.
  always_comb begin
    resp_seen_s = (out_resp_in != RESP_ZERO);
    if (lat_q == LAT_MAX) begin
      lat_d = lat_q;
    end else begin
      lat_d = lat_q + LAT_ONE;
    end
  end

  // Transaction FSM with registered request bus, result fields and error flag.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      op2_q         <= DATA_ZERO;
      lat_q         <= LAT_ZERO;
      req_cmd_q     <= CMD_ZERO;
      req_data_q    <= DATA_ZERO;
      res_valid_q   <= 1'b0;
      res_resp_q    <= RESP_ZERO;
      res_data_q    <= DATA_ZERO;
      res_timeout_q <= 1'b0;
      res_latency_q <= LAT_ZERO;
      err_q         <= 1'b0;
    end else begin
      // Only WAIT_RESP may legitimately see a response; anything else is sticky error.
      if (resp_seen_s && (state_q != S_WAIT_RESP)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op != CMD_ZERO) begin
              req_cmd_q  <= cmd_op;
              req_data_q <= cmd_data1;
              op2_q      <= cmd_data2;
              state_q    <= S_SEND_OP1;
            end else begin
              res_valid_q   <= 1'b1;
              res_resp_q    <= RESP_ZERO;
              res_data_q    <= DATA_ZERO;
              res_timeout_q <= 1'b0;
              res_latency_q <= LAT_ZERO;
              state_q       <= S_DONE;
            end
          end
        end
        S_SEND_OP1: begin
          req_cmd_q  <= CMD_ZERO;
          req_data_q <= op2_q;
          state_q    <= S_SEND_OP2;
        end
        S_SEND_OP2: begin
          req_cmd_q  <= CMD_ZERO;
          req_data_q <= DATA_ZERO;
          lat_q      <= LAT_ONE;
          state_q    <= S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          // A response arriving on the timeout edge still wins.
          if (resp_seen_s) begin
            res_valid_q   <= 1'b1;
            res_resp_q    <= out_resp_in;
            res_data_q    <= out_data_in;
            res_timeout_q <= 1'b0;
            res_latency_q <= lat_q;
            state_q       <= S_DONE;
          end else if (lat_q == LAT_TIMEOUT) begin
            res_valid_q   <= 1'b1;
            res_resp_q    <= RESP_ZERO;
            res_data_q    <= DATA_ZERO;
            res_timeout_q <= 1'b1;
            res_latency_q <= LAT_TIMEOUT;
            state_q       <= S_DONE;
          end else begin
            lat_q <= lat_d;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          req_cmd_q   <= CMD_ZERO;
          req_data_q  <= DATA_ZERO;
          res_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign req_cmd_out    = req_cmd_q;
  assign req_data_out   = req_data_q;
  assign res_valid      = res_valid_q;
  assign res_resp       = res_resp_q;
  assign res_data       = res_data_q;
  assign res_timeout    = res_timeout_q;
  assign res_latency    = res_latency_q;
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_calc_port_initiator.sv
// Bench for calc_port_initiator: directed scenarios plus random traffic, compared
// every cycle against a transaction-level model counting cycles since acceptance.
module tb_calc_port_initiator;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int RW = 2;
  localparam int TO = 8;
  localparam int LW = 8;

  logic          c_clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_op;
  logic [DW-1:0] cmd_data1, cmd_data2;
  logic [CW-1:0] req_cmd_out;
  logic [DW-1:0] req_data_out;
  logic [RW-1:0] out_resp_in;
  logic [DW-1:0] out_data_in;
  logic          res_valid, res_ready;
  logic [RW-1:0] res_resp;
  logic [DW-1:0] res_data;
  logic          res_timeout;
  logic [LW-1:0] res_latency;
  logic          busy, err_unexpected;

  always #5 c_clk = ~c_clk;

  calc_port_initiator #(.DATA_W(DW), .CMD_W(CW), .RESP_W(RW), .TIMEOUT(TO), .LAT_W(LW)) dut (
    .c_clk(c_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data1(cmd_data1), .cmd_data2(cmd_data2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .out_resp_in(out_resp_in), .out_data_in(out_data_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_resp(res_resp),
    .res_data(res_data), .res_timeout(res_timeout), .res_latency(res_latency),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Model: m_k counts cycles since acceptance (1 = operand-1 cycle, 3.. = waiting).
  bit            m_busy, m_done, m_err, m_to;
  int            m_k;
  logic [CW-1:0] m_op;
  logic [DW-1:0] m_d1, m_d2, m_data;
  logic [RW-1:0] m_resp;
  logic [LW-1:0] m_lat;
  int            r_target;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit m_waiting();
    return m_busy && !m_done && (m_k >= 3);
  endfunction

  function automatic int m_w();
    return m_k - 2;
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_busy = 0; m_done = 0; m_err = 0; m_to = 0; m_k = 0;
      m_op = '0; m_d1 = '0; m_d2 = '0; m_data = '0; m_resp = '0; m_lat = '0;
    end else begin
      if (out_resp_in != 0 && !m_waiting()) m_err = 1;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1;
          if (cmd_op == 0) begin
            m_done = 1; m_resp = '0; m_data = '0; m_lat = '0; m_to = 0;
          end else begin
            m_k = 1; m_op = cmd_op; m_d1 = cmd_data1; m_d2 = cmd_data2;
          end
        end
      end else if (m_done) begin
        if (res_ready) begin
          m_busy = 0; m_done = 0; m_k = 0;
        end
      end else if (m_waiting()) begin
        if (out_resp_in != 0) begin
          m_done = 1; m_resp = out_resp_in; m_data = out_data_in; m_lat = LW'(m_w()); m_to = 0;
        end else if (m_w() == TO) begin
          m_done = 1; m_resp = '0; m_data = '0; m_lat = LW'(TO); m_to = 1;
        end else begin
          m_k++;
        end
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic check_all();
    logic [CW-1:0] e_cmd;
    logic [DW-1:0] e_data;
    e_cmd = '0;
    e_data = '0;
    if (m_busy && !m_done && m_k == 1) begin
      e_cmd = m_op; e_data = m_d1;
    end else if (m_busy && !m_done && m_k == 2) begin
      e_data = m_d2;
    end
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("req_cmd_out", req_cmd_out, e_cmd);
    chk("req_data_out", req_data_out, e_data);
    chk("res_valid", res_valid, m_done);
    chk("res_resp", res_resp, m_resp);
    chk("res_data", res_data, m_data);
    chk("res_timeout", res_timeout, m_to);
    chk("res_latency", res_latency, m_lat);
    chk("err_unexpected", err_unexpected, m_err);
  endtask

  task automatic tick();
    model_edge();
    @(negedge c_clk);
    check_all();
  endtask

  task automatic run_txn(input logic [CW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int rr, input logic [RW-1:0] rsp, input logic [DW-1:0] rd);
    cmd_valid = 1'b1; cmd_op = op; cmd_data1 = a; cmd_data2 = b;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && !m_done; i++) begin
      if (m_waiting() && m_w() == rr) begin
        out_resp_in = rsp; out_data_in = rd;
      end else begin
        out_resp_in = '0; out_data_in = '0;
      end
      tick();
    end
    out_resp_in = '0;
    out_data_in = '0;
    chk("txn_done", res_valid, 1'b1);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data1 = '0; cmd_data2 = '0;
    out_resp_in = '0; out_data_in = '0; res_ready = 1'b0;
    m_busy = 0; m_done = 0; m_err = 0; m_to = 0; m_k = 0; r_target = 1;
    m_op = '0; m_d1 = '0; m_d2 = '0; m_data = '0; m_resp = '0; m_lat = '0;

    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);

    // Add 5+3, response on the 4th waiting cycle
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_data1 = 32'd5; cmd_data2 = 32'd3;
    tick();
    cmd_valid = 1'b0;
    chk("add_bus1_cmd", req_cmd_out, 4'd1);
    chk("add_bus1_data", req_data_out, 32'd5);
    tick();
    chk("add_bus2_cmd", req_cmd_out, 4'd0);
    chk("add_bus2_data", req_data_out, 32'd3);
    tick();
    chk("add_bus3_data", req_data_out, 32'd0);
    tick(); tick(); tick();
    out_resp_in = 2'd1; out_data_in = 32'd8;
    tick();
    out_resp_in = 2'd0; out_data_in = 32'd0;
    chk("add_valid", res_valid, 1'b1);
    chk("add_resp", res_resp, 2'd1);
    chk("add_data", res_data, 32'd8);
    chk("add_lat", res_latency, 8'd4);
    chk("add_to", res_timeout, 1'b0);

    // Backpressure
    for (int i = 0; i < 10; i++) tick();
    chk("bp_data", res_data, 32'd8);
    chk("bp_ready", cmd_ready, 1'b0);
    chk("bp_busy", busy, 1'b1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_release_valid", res_valid, 1'b0);
    chk("bp_release_ready", cmd_ready, 1'b1);

    // Timeout, then a late response
    cmd_valid = 1'b1; cmd_op = 4'd2; cmd_data1 = 32'd7; cmd_data2 = 32'd9;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 8; i++) tick();
    chk("to_flag", res_timeout, 1'b1);
    chk("to_lat", res_latency, 8'd8);
    chk("to_resp", res_resp, 2'd0);
    tick();
    out_resp_in = 2'd1; out_data_in = 32'hDEAD;
    tick();
    out_resp_in = 2'd0; out_data_in = 32'd0;
    chk("late_err", err_unexpected, 1'b1);
    chk("late_data", res_data, 32'd0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // Unexpected response in IDLE, sticky across a full transaction
    reset = 1'b0; tick(); reset = 1'b1; tick();
    chk("unx_clear", err_unexpected, 1'b0);
    out_resp_in = 2'd2; tick(); out_resp_in = 2'd0;
    chk("unx_set", err_unexpected, 1'b1);
    tick();
    run_txn(4'd1, 32'd10, 32'd20, 2, 2'd1, 32'd30);
    chk("unx_sticky", err_unexpected, 1'b1);
    chk("unx_txn_data", res_data, 32'd30);
    chk("unx_txn_lat", res_latency, 8'd2);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    reset = 1'b0; tick(); reset = 1'b1;
    chk("unx_rst", err_unexpected, 1'b0);
    tick();

    // Reset while sending operand 2
    cmd_valid = 1'b1; cmd_op = 4'd3; cmd_data1 = 32'h11; cmd_data2 = 32'h22;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_cmd", req_cmd_out, 4'd0);
    chk("mid_rst_data", req_data_out, 32'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", res_valid, 1'b0);
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", cmd_ready, 1'b1);

    // No-op then shift-left 1<<4
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_data1 = 32'h55; cmd_data2 = 32'h66;
    tick();
    chk("noop_valid", res_valid, 1'b1);
    chk("noop_resp", res_resp, 2'd0);
    chk("noop_bus", req_cmd_out, 4'd0);
    res_ready = 1'b1; cmd_op = 4'd5; cmd_data1 = 32'h1; cmd_data2 = 32'd4;
    tick();
    res_ready = 1'b0;
    run_txn(4'd5, 32'h1, 32'd4, 3, 2'd1, 32'h10);
    chk("shl_data", res_data, 32'h10);
    chk("shl_resp", res_resp, 2'd1);
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 199) != 0);
      if (!m_busy) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd_op    = ($urandom_range(0, 4) == 0) ? 4'd0 : CW'($urandom);
        r_target  = $urandom_range(1, TO + 2);
      end else begin
        cmd_valid = ($urandom_range(0, 1) != 0);
        cmd_op    = CW'($urandom);
      end
      cmd_data1 = $urandom;
      cmd_data2 = $urandom;
      res_ready = ($urandom_range(0, 2) == 0);
      if (m_waiting()) begin
        out_resp_in = (m_w() == r_target) ? RW'($urandom_range(1, 3)) : 2'd0;
      end else begin
        out_resp_in = ($urandom_range(0, 19) == 0) ? RW'($urandom_range(1, 3)) : 2'd0;
      end
      out_data_in = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
